// File: rtl/cpu_pkg.sv
// Shared types and widths for the vector CPU pipeline control.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        VEC     = 2'd1,
        LDSTALL = 2'd2
    } issue_state_t;

    localparam int COL_W       = 2;
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/vec_issue_hazard_detect.sv
// Load-use compare between the ID source registers and a loading EX instruction.
// Purely combinational; x0 never counts as a dependency.
module hazard_detect #(
    parameter int REG_AW = 4
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regWrite,
    input  logic              ex_resultSrc,
    output logic              load_use
);

    logic rd_nonzero;
    logic rd_match;

    assign rd_nonzero = |ex_rd;
    assign rd_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    assign load_use   = id_valid && ex_resultSrc && ex_regWrite && rd_nonzero && rd_match;

endmodule

// File: rtl/vec_issue_ctrl.sv
// Decode/execute issue control: column sequencing, load-use bubbles, branch flush, memory freeze.
// Controls are combinational in the same cycle; only the column index and stall count are registered.
module vec_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_COLS = 4,
    parameter int REG_AW   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic                   id_is_vector,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   ex_regWrite,
    input  logic                   ex_resultSrc,
    input  logic                   ex_branch_taken,
    input  logic                   mem_busy,
    output logic                   stop_if,
    output logic                   stop_id,
    output logic                   flush_id,
    output logic                   bubble_ex,
    output logic [COL_W-1:0]       column,
    output logic                   col_last,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [COL_W-1:0]       LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = '1;

    issue_state_t     state_q, state_d;
    logic [COL_W-1:0] column_q, column_d;
    logic             load_use;

    hazard_detect #(
        .REG_AW(REG_AW)
    ) u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_regWrite (ex_regWrite),
        .ex_resultSrc(ex_resultSrc),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            column_q <= '0;
        end else begin
            state_q  <= state_d;
            column_q <= column_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        column_d  = column_q;
        stop_if   = 1'b0;
        stop_id   = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        col_last  = 1'b0;

        if (state_q == VEC && column_q == LAST_COL) begin
            col_last = 1'b1;
        end

        if (ex_branch_taken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = RUN;
            column_d  = '0;
        end else if (mem_busy) begin
            stop_if = 1'b1;
            stop_id = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    column_d = '0;
                    if (load_use) begin
                        // ID/EX keeps loading so the bubble lands behind the load
                        stop_if   = 1'b1;
                        bubble_ex = 1'b1;
                        state_d   = LDSTALL;
                    end else if (id_valid && id_is_vector) begin
                        stop_if  = 1'b1;
                        state_d  = VEC;
                        column_d = COL_W'(1);
                    end
                end
                LDSTALL: begin
                    state_d = RUN;
                end
                VEC: begin
                    if (column_q == LAST_COL) begin
                        state_d  = RUN;
                        column_d = '0;
                    end else begin
                        stop_if  = 1'b1;
                        column_d = column_q + COL_W'(1);
                    end
                end
                default: begin
                    state_d  = RUN;
                    column_d = '0;
                end
            endcase
        end

        // Reset must silence controls even while the inputs are active
        if (!reset_n) begin
            stop_if   = 1'b0;
            stop_id   = 1'b0;
            flush_id  = 1'b0;
            bubble_ex = 1'b0;
            col_last  = 1'b0;
        end
    end

    assign column = column_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stop_if && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: doc/vec_issue_ctrl.md
# vec_issue_ctrl

Pipeline issue controller for the vector encryption CPU's decode-to-execute boundary. It drives the `stop` and bubble controls of the IF/ID and ID/EX pipeline registers. It sequences each vector instruction across `NUM_COLS` columns by generating the 2-bit column index. It also detects load-use hazards and handles taken-branch flushes and external memory stalls.

## Interface

Parameters:
- `NUM_COLS`, default 4: columns per vector instruction; legal range 2..4.
- `REG_AW`, default 4: register address width.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `id_valid`, in, 1: the ID stage holds a valid decoded instruction.
- `id_is_vector`, in, 1: the ID instruction iterates over all columns.
- `id_rs1`, in, REG_AW: ID source register 1.
- `id_rs2`, in, REG_AW: ID source register 2.
- `ex_rd`, in, REG_AW: EX destination register.
- `ex_regWrite`, in, 1: EX instruction writes `ex_rd`.
- `ex_resultSrc`, in, 1: EX instruction is a load (result comes from memory).
- `ex_branch_taken`, in, 1: branch resolved taken in EX.
- `mem_busy`, in, 1: memory is not ready; the whole front end must freeze.
- `stop_if`, out, 1: hold the PC and the IF/ID register.
- `stop_id`, out, 1: drives the ID/EX register `stop`.
- `flush_id`, out, 1: zero the IF/ID register contents on the next edge.
- `bubble_ex`, out, 1: force the ID/EX control flags to 0 on the next edge.
- `column`, out, 2: column index fed to the ID/EX `column_in`.
- `col_last`, out, 1: `column == NUM_COLS-1` while in VEC.
- `stall_cnt`, out, 16: saturating count of cycles in which `stop_if` was 1.

## Operation

The controller has three states: RUN, VEC and LDSTALL. `column` is a registered counter. All other control outputs are combinational from the state, the counter and the inputs.

Priority each cycle, highest first:

1. **Branch taken.** If `ex_branch_taken` is 1:
   - `flush_id`=1 and `bubble_ex`=1.
   - `stop_if`=0 and `stop_id`=0.
   - Next state is RUN and `column` is cleared to 0, aborting any vector sequence in progress.
2. **Memory busy.** If `mem_busy` is 1:
   - `stop_if`=1 and `stop_id`=1.
   - No flush, no bubble.
   - State and `column` are held.
3. **Load-use hazard** (evaluated in RUN only). A hazard exists when all of the following hold: `id_valid`, `ex_resultSrc`, `ex_regWrite`, `ex_rd` is nonzero, and `ex_rd` equals `id_rs1` or `id_rs2`. On a hazard:
   - `stop_if`=1 and `bubble_ex`=1.
   - `stop_id`=0, so the bubble is latched into ID/EX.
   - Next state is LDSTALL.
4. **LDSTALL.** Lasts exactly one cycle: all controls are 0 and the next state is RUN. Hazard detection is suppressed in this state, so one load produces exactly one bubble.
5. **Vector start.** In RUN with `id_valid` and `id_is_vector` both 1:
   - The current cycle issues column 0.
   - `stop_if`=1.
   - Next state is VEC with `column` set to 1.
6. **VEC.** Each cycle issues the current `column` into ID/EX and increments it.
   - `stop_if`=1 while `column` is below `NUM_COLS-1`.
   - On the last column, `stop_if`=0 and `col_last`=1; next state is RUN and `column` wraps to 0.
7. **Default.** In RUN with no other condition active: all controls are 0 and `column` is 0.

`stall_cnt` increments on every cycle where `stop_if` is 1 and saturates at 0xFFFF. It is never cleared except by reset.

## Timing

- **Reset.** While `reset_n` is 0:
  - State is RUN and `column`=0.
  - `stall_cnt`=0.
  - All control outputs are forced to 0, independent of the inputs.
  - Reset takes effect asynchronously, including in the middle of a vector sequence; any partial vector sequence is discarded.
- **Scalar instruction:** zero added latency, no stall.
- **Vector instruction:** occupies ID for exactly `NUM_COLS` cycles. `column` values 0, 1, …, `NUM_COLS-1` appear on consecutive non-frozen cycles.
- **Load-use:** exactly 1 bubble cycle is inserted.
- **`mem_busy` during VEC:** the column sequence freezes and resumes at the same column; no column is skipped or repeated into ID/EX.
- **Simultaneous events:**
  - A branch in the same cycle as a hazard, `mem_busy` or a vector start: the branch wins.
  - `mem_busy` together with a hazard: the freeze applies, and the hazard is re-evaluated on the next cycle.

## Structure

- The shared package `cpu_pkg` holds:
  - the state enum `issue_state_t` (RUN, VEC, LDSTALL);
  - `COL_W`=2;
  - `STALL_CNT_W`=16.
- Sub-module `hazard_detect` is purely combinational and produces the load-use compare. It is reused later for forwarding.
- The FSM, column counter and stall counter stay in `vec_issue_ctrl`.

## Test plan

- **Reset mid-vector.** Set `id_valid`=1 and `id_is_vector`=1, then assert `reset_n`=0 while `column`=2. Required: all outputs 0 immediately; after release, state RUN and `column`=0.
- **Vector sequence** (`NUM_COLS`=4, vector instruction, no stalls). Required: `column` reads 0,1,2,3 on four consecutive cycles; `stop_if` reads 1,1,1,0; `col_last`=1 only on column 3.
- **Load-use.** Set `ex_resultSrc`=1, `ex_regWrite`=1, `ex_rd`=5 and `id_rs2`=5. Required: exactly one cycle with `stop_if`=1, `bubble_ex`=1, `stop_id`=0; the next cycle has all controls 0. Repeat with `ex_rd`=0: no stall.
- **Memory freeze during vector.** Assert `mem_busy` for 3 cycles while at column 1. Required: `stop_if`=`stop_id`=1 and `column` stays at 1 throughout; the sequence then continues with 1,2,3; `stall_cnt` has increased by 3 plus the vector stall cycles.
- **Branch abort.** Assert `ex_branch_taken` at column 2 together with a pending hazard. Required: `flush_id`=1, `bubble_ex`=1, `stop_if`=0; next state RUN with `column`=0.
- **Counter saturation.** Preload `stall_cnt` near 0xFFFF via a long `mem_busy`. Required: the count holds at 0xFFFF and does not wrap.
